// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID scan controller.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    HOST  = 3'd4
  } state_t;

  localparam logic SID_ADDR_ID = 1'b0;
  localparam logic SID_ADDR_TS = 1'b1;

  // Wait counter width; holds SETTLE in 1..15.
  localparam int WCNT_W = 4;

endpackage

// File: rtl/sysid_rescan_timer.sv
// Idle-time rescan timer for sysid_scan_ctrl.
// Built only when SYSID_PERIODIC_RESCAN_EN is defined; in the default build
// this file contributes no module.
`ifdef SYSID_PERIODIC_RESCAN_EN
module sysid_rescan_timer #(
  parameter int unsigned PERIOD = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic in_idle,
  output logic tick
);

  logic [31:0] idle_cnt;

  // Count consecutive IDLE cycles; any non-IDLE cycle restarts the count.
  always_ff @(posedge clock) begin
    if (reset || !in_idle) idle_cnt <= '0;
    else                   idle_cnt <= idle_cnt + 32'd1;
  end

  // Tick during the PERIOD-th idle cycle so the scan enters right after it.
  assign tick = (PERIOD != 0) && in_idle && (idle_cnt == 32'(PERIOD - 1));

endmodule
`endif

// File: rtl/sysid_scan_ctrl.sv
// Boot-time/system-ID scan sequencer and host arbiter for the sysid slave.
// Reads ID (addr 0) and timestamp (addr 1), compares against expected
// values, and lends the slave to a single host requester when idle.
// Optional feature macro: SYSID_PERIODIC_RESCAN_EN (periodic idle rescan).
module sysid_scan_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID = 32'h0000_0000,
  parameter logic [31:0] EXP_TS = 32'h547C_DA9F,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PERIOD = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        host_req,
  input  logic        host_addr,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  localparam logic [WCNT_W-1:0] SETTLE_W = WCNT_W'(SETTLE);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              scan_pend;   // auto-scan owed after reset
  logic              rescan_tick;

`ifdef SYSID_PERIODIC_RESCAN_EN
  sysid_rescan_timer #(.PERIOD(PERIOD)) u_rescan_timer (
    .clock   (clock),
    .reset   (reset),
    .in_idle (state == IDLE),
    .tick    (rescan_tick)
  );
`else
  assign rescan_tick = 1'b0;
`endif

  // Main sequencer: arbitration, settle wait, capture and compare.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      scan_pend   <= 1'b1;
      wcnt        <= '0;
      sid_address <= 1'b0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      mismatch    <= 1'b0;
      id_word     <= '0;
      ts_word     <= '0;
    end else begin
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Scan requests win over the host; start outside IDLE is dropped.
          if (scan_pend || start || rescan_tick) begin
            state       <= RD_ID;
            scan_pend   <= 1'b0;
            busy        <= 1'b1;
            wcnt        <= SETTLE_W;
            sid_address <= SID_ADDR_ID;
          end else if (host_req) begin
            state       <= HOST;
            host_gnt    <= 1'b1;
            wcnt        <= SETTLE_W;
            sid_address <= host_addr;
          end
        end
        RD_ID: begin
          if (wcnt != '0) wcnt <= wcnt - 1'b1;
          else begin
            id_word     <= sid_readdata;
            state       <= RD_TS;
            wcnt        <= SETTLE_W;
            sid_address <= SID_ADDR_TS;
          end
        end
        RD_TS: begin
          if (wcnt != '0) wcnt <= wcnt - 1'b1;
          else begin
            ts_word     <= sid_readdata;
            state       <= CMP;
            sid_address <= SID_ADDR_ID;
          end
        end
        CMP: begin
          id_ok    <= (id_word == EXP_ID);
          ts_ok    <= (ts_word == EXP_TS);
          mismatch <= ~((id_word == EXP_ID) && (ts_word == EXP_TS));
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        HOST: begin
          if (wcnt != '0) wcnt <= wcnt - 1'b1;
          else begin
            host_rdata  <= sid_readdata;
            host_rvalid <= 1'b1;
            state       <= IDLE;
            sid_address <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_scan_ctrl.sv
// Self-checking bench for sysid_scan_ctrl with a behavioural slave and
// a word-level expectation model.
module tb_sysid_scan_ctrl;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h547C_DA9F;
  localparam int SETTLE = 1;
  localparam int RD_LEN = SETTLE + 1;        // cycles per read
  localparam int SCAN_LAT = 2 * RD_LEN + 1;  // entry edge to status edge
`ifdef SYSID_PERIODIC_RESCAN_EN
  localparam int TB_PERIOD = 20;
`else
  localparam int TB_PERIOD = 1000000;
`endif

  logic        clock = 1'b0;
  logic        reset, start, host_req, host_addr;
  logic        sid_address, host_gnt, host_rvalid;
  logic        busy, done, id_ok, ts_ok, mismatch;
  logic [31:0] sid_readdata, host_rdata, id_word, ts_word;
  logic [31:0] slv_id, slv_ts;

  int checks = 0;
  int failures = 0;

  // model of the last completed scan
  logic m_id_ok, m_ts_ok, m_mm;

  always #5 clock = ~clock;

  // behavioural sysid slave: combinational read of two words
  assign sid_readdata = sid_address ? slv_ts : slv_id;

  sysid_scan_ctrl #(
    .EXP_ID(EXP_ID), .EXP_TS(EXP_TS), .SETTLE(SETTLE), .PERIOD(TB_PERIOD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .sid_address  (sid_address),
    .sid_readdata (sid_readdata),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .busy         (busy),
    .done         (done),
    .id_ok        (id_ok),
    .ts_ok        (ts_ok),
    .mismatch     (mismatch),
    .id_word      (id_word),
    .ts_word      (ts_word)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {24'd0, busy, done, id_ok, ts_ok, mismatch,
                          host_gnt, host_rvalid, sid_address}, 32'd0);
    chk({tag, "_id"}, id_word, 32'd0);
    chk({tag, "_ts"}, ts_word, 32'd0);
    chk({tag, "_hrd"}, host_rdata, 32'd0);
  endtask

  // model a completed scan over the given slave contents
  task automatic model_scan(input logic [31:0] iv, input logic [31:0] tv);
    m_id_ok = (iv == EXP_ID);
    m_ts_ok = (tv == EXP_TS);
    m_mm    = !(m_id_ok && m_ts_ok);
  endtask

  task automatic chk_status(input string tag, input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idok"}, id_ok, m_id_ok);
    chk({tag, "_tsok"}, ts_ok, m_ts_ok);
    chk({tag, "_mm"}, mismatch, m_mm);
    chk({tag, "_idw"}, id_word, iv);
    chk({tag, "_tsw"}, ts_word, tv);
  endtask

  // start a scan from IDLE; optionally poke start mid-scan (must be ignored)
  task automatic run_scan(input string tag, input logic [31:0] iv,
                          input logic [31:0] tv, input bit poke);
    slv_id = iv; slv_ts = tv;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    chk({tag, "_enter"}, busy, 1);
    if (poke) begin
      tick_n(1);
      start = 1'b1;
      tick_n(1);
      start = 1'b0;
      tick_n(SCAN_LAT - 3);
    end else tick_n(SCAN_LAT - 1);
    chk({tag, "_hold_busy"}, busy, 1);
    chk({tag, "_hold_mm"}, mismatch, m_mm);
    tick_n(1);
    model_scan(iv, tv);
    chk_status(tag, iv, tv);
    tick_n(2);
    chk({tag, "_stay_idle"}, busy, 0);
    chk({tag, "_addr_idle"}, sid_address, 0);
  endtask

  // host read from IDLE; checks grant latency, rvalid timing and data
  task automatic host_read(input string tag, input logic a);
    int n;
    logic [31:0] exp_d;
    exp_d = a ? slv_ts : slv_id;
    host_req = 1'b1; host_addr = a;
    n = 0;
    do begin
      tick_n(1);
      n++;
    end while (!host_gnt && n < 20);
    chk({tag, "_gnt_lat"}, n, 1);
    host_req = 1'b0;
    tick_n(RD_LEN - 1);
    chk({tag, "_rv_early"}, host_rvalid, 0);
    tick_n(1);
    chk({tag, "_rvalid"}, host_rvalid, 1);
    chk({tag, "_rdata"}, host_rdata, exp_d);
    tick_n(1);
    chk({tag, "_rv_pulse"}, host_rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iv, tv;
    logic        a;
    reset = 1'b1; start = 1'b0; host_req = 1'b0; host_addr = 1'b0;
    slv_id = 32'd0; slv_ts = EXP_TS;
    m_id_ok = 0; m_ts_ok = 0; m_mm = 0;

    // reset state and auto-scan
    tick_n(3);
    chk_all_zero("rst");
    reset = 1'b0;
    tick_n(1);
    chk("boot_busy", busy, 1);
    tick_n(SCAN_LAT - 1);
    chk("boot_done_early", done, 0);
    tick_n(1);
    model_scan(32'd0, EXP_TS);
    chk_status("boot", 32'd0, EXP_TS);

    // bad timestamp
    run_scan("badts", 32'd0, 32'h1234_5678, 0);

    // host read of timestamp
    slv_ts = EXP_TS;
    host_read("host1", 1'b1);
    host_read("host0", 1'b0);

    // start and host_req together: scan first, host next
    slv_id = 32'hDEAD_BEEF; slv_ts = EXP_TS;
    start = 1'b1; host_req = 1'b1; host_addr = 1'b1;
    tick_n(1);
    start = 1'b0;
    chk("coll_busy", busy, 1);
    chk("coll_nognt", host_gnt, 0);
    tick_n(SCAN_LAT - 1);
    chk("coll_nognt2", host_gnt, 0);
    tick_n(1);
    model_scan(32'hDEAD_BEEF, EXP_TS);
    chk_status("coll", 32'hDEAD_BEEF, EXP_TS);
    chk("coll_nognt3", host_gnt, 0);
    tick_n(1);
    chk("coll_gnt", host_gnt, 1);
    host_req = 1'b0;
    tick_n(RD_LEN);
    chk("coll_rvalid", host_rvalid, 1);
    chk("coll_rdata", host_rdata, EXP_TS);

    // reset in the middle of RD_TS
    tick_n(1);
    slv_id = 32'd0; slv_ts = EXP_TS;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
    tick_n(RD_LEN + 1);
    reset = 1'b1;
    tick_n(1);
    chk_all_zero("midrst");
    reset = 1'b0;
    m_id_ok = 0; m_ts_ok = 0; m_mm = 0;
    tick_n(1);
    chk("midrst_busy", busy, 1);
    tick_n(SCAN_LAT - 1);
    chk("midrst_done_early", done, 0);
    tick_n(1);
    model_scan(32'd0, EXP_TS);
    chk_status("midrst", 32'd0, EXP_TS);

    // reset in the middle of a host read: no rvalid afterwards
    host_req = 1'b1; host_addr = 1'b1;
    tick_n(1);
    chk("hrst_gnt", host_gnt, 1);
    host_req = 1'b0;
    reset = 1'b1;
    tick_n(1);
    chk_all_zero("hrst");
    reset = 1'b0;
    m_id_ok = 0; m_ts_ok = 0; m_mm = 0;
    for (int i = 0; i < SCAN_LAT + 2; i++) begin
      tick_n(1);
      chk("hrst_norv", host_rvalid, 0);
    end
    model_scan(32'd0, EXP_TS);
    chk_status("hrst_scan", 32'd0, EXP_TS);

    // randomized scans and host reads
    for (int k = 0; k < 16; k++) begin
      iv = $urandom_range(0, 1) ? EXP_ID : $urandom;
      tv = $urandom_range(0, 1) ? EXP_TS : $urandom;
      case ($urandom_range(0, 2))
        0: run_scan("rscan", iv, tv, 0);
        1: begin
          slv_id = iv; slv_ts = tv;
          a = 1'($urandom_range(0, 1));
          host_read("rhost", a);
        end
        default: run_scan("rpoke", iv, tv, 1);
      endcase
    end

    // periodic rescan (or its absence)
    tick_n(1);
    slv_id = 32'd0; slv_ts = EXP_TS;
    run_scan("pre_idle", 32'd0, EXP_TS, 0);
    // run_scan ends 2 idle cycles past the status edge
`ifdef SYSID_PERIODIC_RESCAN_EN
    tick_n(TB_PERIOD - 3);
    chk("per_not_yet", busy, 0);
    tick_n(1);
    chk("per_rescan", busy, 1);
    tick_n(SCAN_LAT);
    chk_status("per", 32'd0, EXP_TS);
`else
    for (int i = 0; i < 10; i++) begin
      tick_n(50);
      chk("no_rescan", busy, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
